pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, 16, width of PC, offsets and addresses.
REQ-002 SHALL have parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port stall  input  1  hold the current PC and issue no new fetch.
REQ-006 SHALL have port halt  input  1  enter HALTED permanently until reset.
REQ-007 SHALL have port branch_en  input  1  taken-branch redirect strobe, one cycle.
REQ-008 SHALL have port branch_off  input  PC_W  sign-extended branch offset, two's complement, from the immediate sign-extension stage.
REQ-009 SHALL have port jump_en  input  1  absolute jump strobe, one cycle.
REQ-010 SHALL have port jump_addr  input  PC_W  absolute jump target.
REQ-011 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-012 SHALL have port imem_addr  output  PC_W  fetch address, valid while imem_req=1.
REQ-013 SHALL have port imem_ack  input  1  fetch complete, accepted only while imem_req=1.
REQ-014 SHALL have port instr_valid  output  1  one-cycle pulse: the fetched instruction is to be executed.
REQ-015 SHALL have port issued_pc  output  PC_W  PC of the last instruction flagged instr_valid.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, HOLD, HALTED.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ with imem_addr=pc.
REQ-018 REQ SHALL hold imem_req=1 and imem_addr stable until imem_ack; on ack, instr_valid=1 that same cycle, issued_pc<=pc, pc<=pc+1.
REQ-019 Branch target SHALL be issued_pc+1+branch_off, truncated mod 2^PC_W (wrap-around, no overflow flag).
REQ-020 A redirect in REQ without imem_ack SHALL be latched as pending; the in-flight fetch SHALL complete, with instr_valid suppressed on its ack, and the next request SHALL use the redirect target.
REQ-021 A redirect coincident with imem_ack SHALL suppress instr_valid for that ack and load pc with the target.
REQ-022 Priority SHALL be halt > jump_en > branch_en > stall > sequential increment; a later redirect SHALL overwrite a pending one.
REQ-023 stall in REQ SHALL NOT drop imem_req; after ack, the FSM SHALL move to HOLD if stall=1.
REQ-024 HOLD SHALL drive imem_req=0 and keep pc; it SHALL return to REQ the first cycle stall=0; redirects in HOLD SHALL update pc directly.
REQ-025 halt SHALL abandon any outstanding request (imem_req=0 next cycle), ignore imem_ack, and enter HALTED; HALTED SHALL be left only by reset.
REQ-026 instr_valid SHALL never be asserted in IDLE, HOLD or HALTED.

Reset
REQ-027 With reset_n=0 at a rising edge: state=IDLE, pc=RESET_PC, issued_pc=RESET_PC, pending redirect cleared, imem_req=0, instr_valid=0.
REQ-028 Reset mid-request SHALL drop imem_req on the next edge; an imem_ack arriving during reset SHALL be ignored.

Structure
REQ-029 State encoding and PC_W default SHALL live in the shared package cpu_pkg.
REQ-030 The next-PC adder/mux SHALL be a sub-module pc_next_calc (combinational: pc, issued_pc, branch_off, jump_addr, selects -> next_pc); all other logic SHALL reside in pc_sequencer.

Verification
REQ-031 Reset, then imem_ack every cycle for 4 requests -> imem_addr 0,1,2,3; instr_valid pulsing on each ack; issued_pc 0..3.
REQ-032 issued_pc=0x0010, branch_en with branch_off=0xFFFC (-4) coincident with ack -> that instr_valid suppressed, next imem_addr=0x000D.
REQ-033 branch_en while REQ waits 3 cycles for ack (issued_pc=0x0005, off=0x0002) -> suppressed ack, next imem_addr=0x0008.
REQ-034 issued_pc=0xFFFE, branch_off=0x0004 -> target 0x0003 (wrap).
REQ-035 Same-cycle jump_en (0x0100) and branch_en -> next imem_addr=0x0100; stall 3 cycles during REQ -> imem_req held until ack, then 0 for the rest of the stall, resumes at pc+1.
REQ-036 halt during outstanding request -> imem_req=0 next cycle, later ack yields no instr_valid; reset_n=0 -> imem_addr restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC width default, sequencer states and
// next-PC select codes.
package cpu_pkg;

  localparam int unsigned PC_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALTED
  } state_t;

  typedef enum logic [1:0] {
    NPC_INC,
    NPC_BRANCH,
    NPC_JUMP
  } npc_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC adder/mux: sequential increment, PC-relative branch
// (relative to the last issued instruction) or absolute jump.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] issued_pc,
  input  logic [PC_W-1:0] branch_off,
  input  logic [PC_W-1:0] jump_addr,
  input  npc_sel_t        sel,
  output logic [PC_W-1:0] next_pc
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Branch target wraps modulo 2^PC_W by construction of the adder width.
  always_comb begin
    next_pc = pc + ONE;
    case (sel)
      NPC_BRANCH: next_pc = issued_pc + ONE + branch_off;
      NPC_JUMP:   next_pc = jump_addr;
      default:    next_pc = pc + ONE;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: issues fetch requests, handles redirects
// (immediate or pending behind an in-flight fetch), stall and halt.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_off,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  output logic [PC_W-1:0] issued_pc
);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [PC_W-1:0] pend_addr, pend_addr_nx;
  logic            pend, pend_nx;
  logic [PC_W-1:0] issued_nx;
  logic [PC_W-1:0] calc_pc;
  logic            redirect;
  npc_sel_t        sel;

  assign redirect  = jump_en | branch_en;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    sel = NPC_INC;
    if (jump_en)        sel = NPC_JUMP;
    else if (branch_en) sel = NPC_BRANCH;
  end

  pc_next_calc #(.PC_W(PC_W)) u_next (
    .pc        (pc),
    .issued_pc (issued_pc),
    .branch_off(branch_off),
    .jump_addr (jump_addr),
    .sel       (sel),
    .next_pc   (calc_pc)
  );

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    pend_nx      = pend;
    pend_addr_nx = pend_addr;
    issued_nx    = issued_pc;
    instr_valid  = 1'b0;
    if (halt) begin
      state_nx = HALTED;
    end else begin
      case (state)
        IDLE: state_nx = REQ;
        REQ: begin
          if (imem_ack) begin
            // Any redirect, current or pending, kills the fetched instruction.
            if (redirect) begin
              pc_nx = calc_pc;
            end else if (pend) begin
              pc_nx = pend_addr;
            end else begin
              instr_valid = reset_n;
              issued_nx   = pc;
              pc_nx       = calc_pc;
            end
            pend_nx  = 1'b0;
            state_nx = stall ? HOLD : REQ;
          end else if (redirect) begin
            pend_nx      = 1'b1;
            pend_addr_nx = calc_pc;
          end
        end
        HOLD: begin
          if (redirect) pc_nx = calc_pc;
          if (!stall)   state_nx = REQ;
        end
        default: state_nx = HALTED;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      issued_pc <= issued_nx;
      pend      <= pend_nx;
      pend_addr <= pend_addr_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a fetch-level reference model predicts
// every cycle's outputs into a queue; a negedge monitor compares them.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, halt, branch_en, jump_en, imem_ack;
  logic [15:0] branch_off, jump_addr;
  logic        imem_req, instr_valid;
  logic [15:0] imem_addr, issued_pc;

  pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .halt       (halt),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .instr_valid(instr_valid),
    .issued_pc  (issued_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] issued;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: architectural fetch stream state.
  bit          m_fresh, m_fetching, m_halted, m_has_pend;
  logic [15:0] m_pc, m_last, m_pend;

  task automatic model_reset();
    m_fresh    = 1'b1;
    m_fetching = 1'b0;
    m_halted   = 1'b0;
    m_has_pend = 1'b0;
    m_pc       = 16'h0000;
    m_last     = 16'h0000;
    m_pend     = 16'h0000;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input bit rst, input bit hlt, input bit stl, input bit br,
                     input logic [15:0] boff, input bit jmp, input logic [15:0] ja,
                     input bit ack);
    exp_t        e;
    logic [15:0] tgt;
    bit          redir;
    @(posedge clock);
    #1;
    reset_n    = !rst;
    halt       = hlt;
    stall      = stl;
    branch_en  = br;
    branch_off = boff;
    jump_en    = jmp;
    jump_addr  = ja;
    imem_ack   = ack;
    redir      = br || jmp;
    e.req    = m_fetching;
    e.addr   = m_pc;
    e.valid  = m_fetching && ack && !rst && !hlt && !redir && !m_has_pend;
    e.issued = m_last;
    q.push_back(e);
    tgt = jmp ? ja : (m_last + 16'd1 + boff);
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
      // stays halted until reset
    end else if (hlt) begin
      m_halted   = 1'b1;
      m_fetching = 1'b0;
      m_fresh    = 1'b0;
    end else if (m_fresh) begin
      m_fresh    = 1'b0;
      m_fetching = 1'b1;
    end else if (m_fetching) begin
      if (ack) begin
        if (redir)           m_pc = tgt;
        else if (m_has_pend) m_pc = m_pend;
        else begin
          m_last = m_pc;
          m_pc   = m_pc + 16'd1;
        end
        m_has_pend = 1'b0;
        m_fetching = !stl;
      end else if (redir) begin
        m_has_pend = 1'b1;
        m_pend     = tgt;
      end
    end else begin
      if (redir) m_pc = tgt;
      m_fetching = !stl;
    end
  endtask

  task automatic ack1();
    cyc(0, 0, 0, 0, 16'h0, 0, 16'h0, 1);
  endtask

  task automatic wait0();
    cyc(0, 0, 0, 0, 16'h0, 0, 16'h0, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_req", {15'b0, imem_req}, {15'b0, e.req});
        if (e.req) chk("imem_addr", imem_addr, e.addr);
        chk("instr_valid", {15'b0, instr_valid}, {15'b0, e.valid});
        chk("issued_pc", issued_pc, e.issued);
      end
    end
  end

  initial begin
    reset_n = 1'b0; halt = 1'b0; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    imem_ack = 1'b0; branch_off = '0; jump_addr = '0;
    repeat (2) @(posedge clock);
    model_reset();

    // Sequential fetch from reset; ack during IDLE must be ignored.
    ack1();
    repeat (4) ack1();
    repeat (13) ack1();
    // Branch -4 coincident with ack at issued_pc 0x10.
    cyc(0, 0, 0, 1, 16'hFFFC, 0, 16'h0, 1);
    // Pending jump to 5, then branch +2 held across 3 wait cycles.
    cyc(0, 0, 0, 0, 16'h0, 1, 16'h0005, 0);
    ack1();
    ack1();
    cyc(0, 0, 0, 1, 16'h0002, 0, 16'h0, 0);
    wait0();
    wait0();
    ack1();
    ack1();
    // Wrap-around branch target from 0xFFFE.
    cyc(0, 0, 0, 0, 16'h0, 1, 16'hFFFE, 1);
    ack1();
    cyc(0, 0, 0, 1, 16'h0004, 0, 16'h0, 1);
    ack1();
    // Jump beats branch; then 3-cycle stall over a fetch.
    cyc(0, 0, 0, 1, 16'h0007, 1, 16'h0100, 1);
    cyc(0, 0, 1, 0, 16'h0, 0, 16'h0, 0);
    cyc(0, 0, 1, 0, 16'h0, 0, 16'h0, 1);
    cyc(0, 0, 1, 0, 16'h0, 0, 16'h0, 1);
    wait0();
    ack1();
    // Halt with outstanding request, acks ignored, reset restarts.
    cyc(0, 1, 0, 0, 16'h0, 0, 16'h0, 0);
    ack1();
    ack1();
    cyc(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    ack1();
    ack1();
    // Reset mid-request with ack during reset.
    wait0();
    cyc(1, 0, 0, 0, 16'h0, 0, 16'h0, 1);
    wait0();
    ack1();
    ack1();

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 199) < 2,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 12,
          16'($urandom), $urandom_range(0, 99) < 6, 16'($urandom),
          $urandom_range(0, 99) < 55);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
